// File: rtl/a5_pkg.sv
// Register geometry, tap masks, step counts and FSM encoding shared by the
// A5/1 keystream engine and its LFSR stages.
package a5_pkg;

  localparam int R1_W = 19;
  localparam int R2_W = 22;
  localparam int R3_W = 23;

  localparam logic [R1_W-1:0] R1_TAPS = 19'h7_2000;
  localparam logic [R2_W-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_W-1:0] R3_TAPS = 23'h70_0080;

  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  localparam int KEY_STEPS   = 64;
  localparam int FRAME_STEPS = 22;

  typedef enum logic [2:0] {IDLE, KEY, FRAME, MIX, RUN, DONE} state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/a5_stream_engine_lfsr.sv
// One A5/1 shift register: shifts in tap parity XOR inject when stepped.
// msb_next is the MSB as it will stand after the current edge.
module a5_lfsr_stage #(
  parameter int             W       = 19,
  parameter logic [W-1:0]   TAPS    = '0,
  parameter int             CLK_BIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic step,
  input  logic inject,
  output logic msb_next,
  output logic clk_bit
);

  logic [W-1:0] r;
  logic         fb;

  assign fb = (^(r & TAPS)) ^ inject;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r <= '0;
    end else if (clear) begin
      r <= '0;
    end else if (step) begin
      r <= {r[W-2:0], fb};
    end
  end

  assign msb_next = step ? r[W-2] : r[W-1];
  assign clk_bit  = r[CLK_BIT];

endmodule

// File: rtl/a5_stream_engine.sv
// A5/1 keystream engine: key/frame load, majority mixing and burst keystream
// packed MSB-first into OUT_W-bit words on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start
// KEY   | 64 steps, all registers clocked, key bit injected
// FRAME | 22 steps, all registers clocked, frame bit injected
// MIX   | MIX_CYCLES majority-clocked steps, output discarded
// RUN   | majority-clocked keystream, holds while the word is stalled
// DONE  | one-cycle done pulse
module a5_stream_engine
  import a5_pkg::*;
#(
  parameter int OUT_W      = 8,
  parameter int KS_BITS    = 228,
  parameter int MIX_CYCLES = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [63:0]      key,
  input  logic [21:0]      frame,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             ks_last
);

  localparam int CNT_W     = $clog2(max3(KEY_STEPS, MIX_CYCLES, KS_BITS)) + 1;
  localparam int LAST_BITS = (KS_BITS % OUT_W == 0) ? OUT_W : (KS_BITS % OUT_W);
  localparam int PAD       = OUT_W - LAST_BITS;
  localparam logic [OUT_W-1:0] LOW_MASK = {OUT_W{1'b1}} >> PAD;
  localparam logic [OUT_W-1:0] COL_INIT = OUT_W'(1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic [63:0]        key_sr;
  logic [21:0]        frame_sr;
  logic [OUT_W-1:0]   col;
  logic [OUT_W:0]     cat;
  logic [OUT_W-1:0]   word_raw, last_word;
  logic               clear, inject, cnt_en, advance, accept;
  logic               s1, s2, s3, c1, c2, c3, n1, n2, n3, maj, bit_nx;
  logic               final_bit, word_done;

  a5_lfsr_stage #(.W(R1_W), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .step(s1), .inject(inject),
    .msb_next(n1), .clk_bit(c1));
  a5_lfsr_stage #(.W(R2_W), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .step(s2), .inject(inject),
    .msb_next(n2), .clk_bit(c2));
  a5_lfsr_stage #(.W(R3_W), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .step(s3), .inject(inject),
    .msb_next(n3), .clk_bit(c3));

  assign maj    = (c1 & c2) | (c1 & c3) | (c2 & c3);
  assign accept = ks_valid & ks_ready;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    inject   = 1'b0;
    cnt_en   = 1'b0;
    advance  = 1'b0;
    s1       = 1'b0;
    s2       = 1'b0;
    s3       = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nx = KEY;
        clear    = 1'b1;
      end
      KEY: begin
        {s1, s2, s3} = 3'b111;
        inject = key_sr[0];
        cnt_en = 1'b1;
        if (cnt == '0) state_nx = FRAME;
      end
      FRAME: begin
        {s1, s2, s3} = 3'b111;
        inject = frame_sr[0];
        cnt_en = 1'b1;
        if (cnt == '0) state_nx = MIX;
      end
      MIX: begin
        s1 = (c1 == maj);
        s2 = (c2 == maj);
        s3 = (c3 == maj);
        cnt_en = 1'b1;
        if (cnt == '0) state_nx = RUN;
      end
      RUN: begin
        // ks_last set means every bit is already out; only the handshake remains
        advance = (!ks_valid || ks_ready) && !ks_last;
        if (advance) begin
          s1 = (c1 == maj);
          s2 = (c2 == maj);
          s3 = (c3 == maj);
          cnt_en = 1'b1;
        end
        if (accept && ks_last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = '0;
    unique case (state_nx)
      KEY:     cnt_load = CNT_W'(KEY_STEPS - 1);
      FRAME:   cnt_load = CNT_W'(FRAME_STEPS - 1);
      MIX:     cnt_load = CNT_W'(MIX_CYCLES - 1);
      RUN:     cnt_load = CNT_W'(KS_BITS - 1);
      default: cnt_load = '0;
    endcase
  end

  // col carries a sentinel one above the collected bits; reaching the MSB marks a full word
  assign bit_nx    = n1 ^ n2 ^ n3;
  assign cat       = {col, bit_nx};
  assign word_raw  = cat[OUT_W-1:0];
  assign last_word = (word_raw & LOW_MASK) << PAD;
  assign final_bit = (cnt == '0);
  assign word_done = col[OUT_W-1] | final_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      key_sr   <= '0;
      frame_sr <= '0;
      col      <= COL_INIT;
      ks_data  <= '0;
      ks_valid <= 1'b0;
      ks_last  <= 1'b0;
    end else begin
      if (state_nx != state)          cnt <= cnt_load;
      else if (cnt_en && cnt != '0)   cnt <= cnt - 1'b1;

      if (clear) begin
        key_sr   <= key;
        frame_sr <= frame;
        col      <= COL_INIT;
      end
      if (state == KEY)   key_sr   <= key_sr >> 1;
      if (state == FRAME) frame_sr <= frame_sr >> 1;

      if (accept) begin
        ks_valid <= 1'b0;
        ks_last  <= 1'b0;
      end
      if (advance) begin
        if (word_done) begin
          ks_data  <= final_bit ? last_word : word_raw;
          ks_valid <= 1'b1;
          ks_last  <= final_bit;
          col      <= COL_INIT;
        end else begin
          col <= word_raw;
        end
      end
    end
  end

endmodule

// File: tb/tb_a5_stream_engine.sv
// Self-checking bench for a5_stream_engine at OUT_W = 8, 1 and 32 against a
// bit-level A5/1 reference and the published known-answer words.
module tb_a5_stream_engine;

  localparam logic [63:0] KAT_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] KAT_FRAME = 22'h134;

  logic        clk, reset_n, start;
  logic [63:0] key_in;
  logic [21:0] frame_in;
  logic        rand_rdy, rdy_fix, rnd_bit, rdy8;

  logic        busy8, done8, ks_valid8, ks_last8;
  logic [7:0]  ks_data8;
  logic        busy1, done1, ks_valid1, ks_last1;
  logic [0:0]  ks_data1;
  logic        busy32, done32, ks_valid32, ks_last32;
  logic [31:0] ks_data32;

  int n_checks = 0;
  int n_errors = 0;
  int n_done8 = 0, n_done1 = 0, n_done32 = 0;

  logic [31:0] q8_d[$], q1_d[$], q32_d[$];
  logic        q8_l[$], q1_l[$], q32_l[$];
  bit          ref_bits [0:227];
  logic [7:0]  kat_w [0:13] = '{8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8, 8'h15,
                                8'h1A, 8'hB6, 8'hE1, 8'h85, 8'h5A, 8'h72, 8'h8C};

  assign rdy8 = rand_rdy ? rnd_bit : rdy_fix;

  a5_stream_engine #(.OUT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key_in), .frame(frame_in),
    .busy(busy8), .done(done8), .ks_data(ks_data8), .ks_valid(ks_valid8),
    .ks_ready(rdy8), .ks_last(ks_last8));

  a5_stream_engine #(.OUT_W(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key_in), .frame(frame_in),
    .busy(busy1), .done(done1), .ks_data(ks_data1), .ks_valid(ks_valid1),
    .ks_ready(1'b1), .ks_last(ks_last1));

  a5_stream_engine #(.OUT_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key_in), .frame(frame_in),
    .busy(busy32), .done(done32), .ks_data(ks_data32), .ks_valid(ks_valid32),
    .ks_ready(1'b1), .ks_last(ks_last32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 9) < 3);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Words are recorded when the handshake is seen; the accepting edge follows.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ks_valid8 && rdy8) begin q8_d.push_back(32'(ks_data8)); q8_l.push_back(ks_last8); end
      if (ks_valid1)  begin q1_d.push_back(32'(ks_data1)); q1_l.push_back(ks_last1); end
      if (ks_valid32) begin q32_d.push_back(ks_data32);    q32_l.push_back(ks_last32); end
      if (done8)  n_done8++;
      if (done1)  n_done1++;
      if (done32) n_done32++;
    end
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk_eq("stall_stable", ks_data8, prev_data);
      prev_stall = ks_valid8 && !rdy8;
      prev_data  = ks_data8;
    end
  end

  task automatic gen_ref(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic        m, ib;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) ib = k[i];
      else        ib = f[i-64];
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ ib};
      b = {b[20:0], b[21] ^ b[20] ^ ib};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ ib};
    end
    for (int i = 0; i < 100 + 228; i++) begin
      m = ((int'(a[8]) + int'(b[10]) + int'(c[10])) >= 2);
      if (a[8] == m)  a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
      if (b[10] == m) b = {b[20:0], b[21] ^ b[20]};
      if (c[10] == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
      if (i >= 100) ref_bits[i-100] = a[18] ^ b[21] ^ c[22];
    end
  endtask

  function automatic logic [31:0] exp_word(input int w, input int width);
    logic [31:0] v;
    int          idx;
    v = '0;
    for (int j = 0; j < width; j++) begin
      idx = w * width + j;
      v = {v[30:0], (idx < 228) ? ref_bits[idx] : 1'b0};
    end
    return v;
  endfunction

  task automatic run_burst(input logic [63:0] k, input logic [21:0] f,
                           input bit rnd, input bit kat);
    int          b8, b1, b32, d8, d1, d32, cyc, first_valid;
    bit          gap;
    logic [31:0] w;
    b8 = q8_d.size(); b1 = q1_d.size(); b32 = q32_d.size();
    d8 = n_done8;     d1 = n_done1;     d32 = n_done32;
    gen_ref(k, f);
    key_in = k; frame_in = f;
    rand_rdy = rnd; rdy_fix = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; first_valid = -1; gap = 1'b0;
    while ((busy8 || busy1 || busy32) && cyc < 4000) begin
      if (!busy8 && n_done8 == d8) gap = 1'b1;
      if (ks_valid8 && first_valid < 0) first_valid = cyc;
      start = (cyc == 40 || cyc == 200);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    rand_rdy = 1'b0;
    chk_eq("burst_timeout", (cyc >= 4000), 0);
    chk_eq("busy_gap", gap, 0);
    if (kat && !rnd) chk_eq("first_valid_latency", first_valid, 194);
    chk_eq("done8_pulses", n_done8 - d8, 1);
    chk_eq("done1_pulses", n_done1 - d1, 1);
    chk_eq("done32_pulses", n_done32 - d32, 1);
    chk_eq("words8", q8_d.size() - b8, 29);
    chk_eq("words1", q1_d.size() - b1, 228);
    chk_eq("words32", q32_d.size() - b32, 8);
    for (int i = 0; i < 29; i++) begin
      chk_eq("w8", q8_d[b8+i], exp_word(i, 8));
      chk_eq("last8", q8_l[b8+i], (i == 28));
    end
    for (int i = 0; i < 228; i++) begin
      chk_eq("w1", q1_d[b1+i], exp_word(i, 1));
      chk_eq("last1", q1_l[b1+i], (i == 227));
    end
    for (int i = 0; i < 8; i++) begin
      chk_eq("w32", q32_d[b32+i], exp_word(i, 32));
      chk_eq("last32", q32_l[b32+i], (i == 7));
    end
    if (kat) begin
      for (int i = 0; i < 14; i++) chk_eq("kat_word", q8_d[b8+i], 32'(kat_w[i]));
      w = q8_d[b8+14];
      chk_eq("kat_w14_msbs", w[7:6], 2'b00);
      chk_eq("kat_w28", q8_d[b8+28], 32'hB0);
      w = q32_d[b32+7];
      chk_eq("w32_tail_zero", w[27:0], 28'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_busy"}, busy8, 0);
    chk_eq({tag, "_done"}, done8, 0);
    chk_eq({tag, "_valid"}, ks_valid8, 0);
    chk_eq({tag, "_last"}, ks_last8, 0);
    chk_eq({tag, "_data"}, ks_data8, 0);
    chk_eq({tag, "_data32"}, ks_data32, 0);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; start = 1'b0;
    key_in = '0; frame_in = '0;
    rand_rdy = 1'b0; rdy_fix = 1'b1;
    #2;
    chk_outputs_zero("reset");
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    run_burst(KAT_KEY, KAT_FRAME, 1'b0, 1'b1);
    run_burst(KAT_KEY, KAT_FRAME, 1'b1, 1'b1);

    key_in = KAT_KEY; frame_in = KAT_FRAME; rdy_fix = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (120) @(posedge clk);
    #2;
    chk_eq("pre_reset_busy", busy8, 1);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("reset_mix");
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    gen_ref(KAT_KEY, KAT_FRAME);
    rdy_fix = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!ks_valid8 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk_eq("stall_valid_seen", ks_valid8, 1);
    repeat (5) @(posedge clk);
    #2;
    chk_eq("stall_valid_held", ks_valid8, 1);
    chk_eq("stall_word0", ks_data8, exp_word(0, 8));
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("reset_stall");
    #3 reset_n = 1'b1;
    rdy_fix = 1'b1;
    @(posedge clk); #1;

    run_burst(KAT_KEY, KAT_FRAME, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++)
      run_burst({$urandom, $urandom}, 22'($urandom), 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
